// File: rtl/adder_3bit_pkg.sv
// adder_3bit_pkg: shared widths and carry-counter saturation limit for adder_3bit
package adder_3bit_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/adder_3bit_full_adder.sv
// full_adder: single-bit full adder cell used in the ripple chain
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/adder_3bit.sv
// adder_3bit: registered ripple-carry adder with saturating carry counter; ADDER_3BIT_OVF_EN adds signed ovf flag
module adder_3bit
  import adder_3bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
`ifdef ADDER_3BIT_OVF_EN
  output logic             ovf,
`endif
  output logic [CNT_W-1:0] carry_cnt
);
  logic [WIDTH-1:0] s;
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.x(a[i]), .y(b[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      carry <= 1'b0;
      out_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= s;
        carry <= c[WIDTH];
        if (c[WIDTH] && carry_cnt != CNT_MAX) carry_cnt <= carry_cnt + 1'b1;
      end
    end
  end
`ifdef ADDER_3BIT_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (in_valid) ovf <= (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  end
`endif
endmodule

// File: tb/tb_adder_3bit.sv
// tb_adder_3bit: table-driven and directed checks of adder_3bit (default WIDTH=3)
module tb_adder_3bit;
  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [2:0] a, b, sum;
  logic carry, out_valid;
  logic [7:0] carry_cnt;
`ifdef ADDER_3BIT_OVF_EN
  logic ovf;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int ecnt = 0;
  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] s;
    logic c;
  } vec_t;
  vec_t tbl[8];

  adder_3bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum), .carry(carry), .out_valid(out_valid),
`ifdef ADDER_3BIT_OVF_EN
    .ovf(ovf),
`endif
    .carry_cnt(carry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [2:0] x, input logic [2:0] y,
                     input logic [2:0] es, input logic ec);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (ec && ecnt != 255) ecnt++;
    chk({n, "_sum"}, int'(sum), int'(es));
    chk({n, "_carry"}, int'(carry), int'(ec));
    chk({n, "_out_valid"}, int'(out_valid), 1);
    chk({n, "_carry_cnt"}, int'(carry_cnt), ecnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    ecnt = 0;
    chk("rst_sum", int'(sum), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_carry_cnt", int'(carry_cnt), 0);
  endtask

  initial begin
    tbl[0] = '{3'd3, 3'd4, 3'b111, 1'b0};
    tbl[1] = '{3'd7, 3'd1, 3'b000, 1'b1};
    tbl[2] = '{3'd0, 3'd0, 3'b000, 1'b0};
    tbl[3] = '{3'd7, 3'd7, 3'b110, 1'b1};
    tbl[4] = '{3'd5, 3'd6, 3'b011, 1'b1};
    tbl[5] = '{3'd2, 3'd5, 3'b111, 1'b0};
    tbl[6] = '{3'd1, 3'd1, 3'b010, 1'b0};
    tbl[7] = '{3'd6, 3'd3, 3'b001, 1'b1};
    in_valid = 1'b0;
    a = '0;
    b = '0;
    rst = 1'b1;
    #2;
    chk("por_sum", int'(sum), 0);
    chk("por_carry", int'(carry), 0);
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_carry_cnt", int'(carry_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) add($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        logic [3:0] t;
        t = 4'(i + j);
        add($sformatf("exh_%0d_%0d", i, j), 3'(i), 3'(j), t[2:0], t[3]);
      end
    add("hold_load", 3'd5, 3'd6, 3'b011, 1'b1);
    in_valid = 1'b0;
    a = 3'd1;
    b = 3'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_sum", k), int'(sum), 3);
      chk($sformatf("hold%0d_carry", k), int'(carry), 1);
      chk($sformatf("hold%0d_out_valid", k), int'(out_valid), 0);
      chk($sformatf("hold%0d_carry_cnt", k), int'(carry_cnt), ecnt);
    end
    add("mid_load", 3'd7, 3'd7, 3'b110, 1'b1);
    a = 3'd3;
    b = 3'd3;
    #2;
    do_reset();
    @(posedge clk);
    #1;
    chk("inrst_sum", int'(sum), 0);
    chk("inrst_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_sum", int'(sum), 0);
    chk("postrst_carry", int'(carry), 0);
    chk("postrst_out_valid", int'(out_valid), 0);
    for (int k = 0; k < 300; k++) add($sformatf("sat%0d", k), 3'd7, 3'd1, 3'b000, 1'b1);
    chk("sat_final", int'(carry_cnt), 255);
    add("sat_nocarry", 3'd1, 3'd2, 3'b011, 1'b0);
    in_valid = 1'b0;
`ifdef ADDER_3BIT_OVF_EN
    add("ovf_a", 3'd3, 3'd1, 3'b100, 1'b0);
    chk("ovf_3_1", int'(ovf), 1);
    add("ovf_b", 3'd4, 3'd4, 3'b000, 1'b1);
    chk("ovf_4_4", int'(ovf), 1);
    add("ovf_c", 3'd2, 3'd1, 3'b011, 1'b0);
    chk("ovf_2_1", int'(ovf), 0);
    in_valid = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk("idle_out_valid", int'(out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adder_3bit.md
ADDER_3BIT -- requirements
Module: adder_3bit

Interface
REQ-001 Parameter: WIDTH, default 3, operand and sum width in bits; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  qualifies a and b for this cycle.
REQ-005 Port: a  input  WIDTH  unsigned addend.
REQ-006 Port: b  input  WIDTH  unsigned addend.
REQ-007 Port: sum  output  WIDTH  registered low WIDTH bits of a+b.
REQ-008 Port: carry  output  1  registered carry-out (bit WIDTH of a+b).
REQ-009 Port: out_valid  output  1  high for exactly one cycle per accepted input.
REQ-010 Port: carry_cnt  output  8  saturating count of accepted additions with carry=1.
REQ-011 Port (only with ADDER_3BIT_OVF_EN): ovf  output  1  registered signed two's-complement overflow flag.

Function
REQ-012 SHALL compute {carry,sum} = a + b as WIDTH+1-bit unsigned result; no carry-in.
REQ-013 SHALL form the sum through a ripple chain of WIDTH full-adder cells, LSB carry-in tied to 0.
REQ-014 SHALL register sum, carry (and ovf) on the rising edge where in_valid=1; latency exactly 1 cycle.
REQ-015 SHALL hold sum, carry, ovf unchanged in cycles where in_valid=0.
REQ-016 SHALL drive out_valid one cycle after each in_valid=1; back-to-back in_valid yields continuous out_valid.
REQ-017 SHALL increment carry_cnt on each accepted addition with carry=1; saturate at 255, never wrap.
REQ-018 Wrap-around: all-ones + 1 SHALL give sum=0, carry=1 (WIDTH=3: 7+1 -> sum 000, carry 1).
REQ-019 Maximum: all-ones + all-ones SHALL give sum = all-ones minus 1, carry=1 (WIDTH=3: 7+7 -> 110, 1).
REQ-020 Outputs SHALL be X-free whenever a and b are X-free.

Reset
REQ-021 rst=1 SHALL immediately, without a clock edge, force sum=0, carry=0, out_valid=0, carry_cnt=0, ovf=0.
REQ-022 Reset asserted mid-operation SHALL discard any pending result; no out_valid after rst deassertion until a new in_valid=1.
REQ-023 First input accepted on the first rising edge with rst=0.

Configuration
REQ-024 Macro ADDER_3BIT_OVF_EN defined: ovf port present; ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), registered with sum.
REQ-025 Macro undefined: ovf port and its logic absent; all other behaviour identical.

Structure
REQ-026 Shared package adder_3bit_pkg SHALL hold the default-width constant (3), the counter width (8) and the counter saturation value (255).
REQ-027 One sub-module full_adder (inputs x, y, cin; outputs s, cout) SHALL be instantiated WIDTH times via generate.

Verification
REQ-028 Exhaustive: all 64 (a,b) pairs 0..7 with in_valid=1 -> each sum/carry equals a+b one cycle later, out_valid=1 throughout.
REQ-029 a=3,b=4 -> sum=111, carry=0; a=7,b=1 -> sum=000, carry=1; a=0,b=0 -> sum=000, carry=0.
REQ-030 in_valid=0 for 5 cycles after a=5,b=6 (sum 011, carry 1) -> outputs hold, out_valid=0.
REQ-031 rst pulsed between clock edges after accepted 7+7 -> sum=0, carry=0, out_valid=0, carry_cnt=0 immediately.
REQ-032 300 consecutive 7+1 additions -> carry_cnt reaches 255 and stays 255.
REQ-033 With ADDER_3BIT_OVF_EN: a=3,b=1 -> ovf=1; a=4,b=4 -> ovf=1; a=2,b=1 -> ovf=0.
